// File: rtl/div_pkg.sv
// Shared types and default sizing for the divided-tick scheduler.
package div_pkg;

  localparam int CW_DEF    = 10;
  localparam int N_REQ_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping upward.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_id,
  output logic             any
);

  logic [IW-1:0] idx;

  // Scan every position starting at ptr; the first hit wins, later hits are ignored.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IW'((int'(ptr) + i) % N_REQ);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_tick_sched.sv
// Programmable tick divider with round-robin grant of each tick to one requester.
// A divisor written while running is parked in a shadow register and takes
// effect at the next period boundary so a period is never cut short.
module div_tick_sched
  import div_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     div_we,
  input  logic [CW-1:0]            div_val,
  input  logic [N_REQ-1:0]         req,
  output logic                     tick,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     div_pend
);

  localparam int IW = $clog2(N_REQ);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_id;
  logic             pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (pick_gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: en alone moves between IDLE and RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: tick and grant are purely combinational so they land in the tick cycle.
  always_comb begin
    busy     = (state_q == RUN);
    tick     = busy && (cnt_q == div_q);
    gnt      = tick ? pick_gnt : '0;
    gnt_id   = (tick && pick_any) ? pick_id : '0;
    div_pend = pend_q;
  end

  // Counter, divisor and pointer next state. A period boundary is either the
  // wrap in the tick cycle or leaving RUN; both apply the newest divisor.
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    ptr_d    = ptr_q;
    if (!busy) begin
      cnt_d = '0;
      if (div_we) div_d = div_val;
    end else if (tick || !en) begin
      cnt_d  = '0;
      pend_d = 1'b0;
      if (div_we)      div_d = div_val;
      else if (pend_q) div_d = shadow_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (div_we) begin
        shadow_d = div_val;
        pend_d   = 1'b1;
      end
    end
    if (tick && pick_any) ptr_d = IW'((int'(pick_id) + 1) % N_REQ);
  end

  // Datapath registers; divisors come out of reset at the longest period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      div_q    <= '1;
      shadow_q <= '1;
      pend_q   <= 1'b0;
      ptr_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: doc/div_tick_sched.md
DIV_TICK_SCHED -- requirements
Module: div_tick_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing the divided tick.
REQ-002 The block SHALL have parameter CW, default 10, giving the divisor and counter width.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  run enable: high runs the divider, low stops it.
REQ-006 div_we  in  1  divisor write strobe.
REQ-007 div_val  in  CW  divisor value; the tick period SHALL be div_val+1 clocks.
REQ-008 req  in  N_REQ  per-requester tick request, level-sensitive.
REQ-009 tick  out  1  one-cycle pulse at the end of each period.
REQ-010 gnt  out  N_REQ  one-hot grant, valid only in the tick cycle; otherwise zero.
REQ-011 gnt_id  out  $clog2(N_REQ)  index of the granted requester, valid when gnt != 0.
REQ-012 busy  out  1  high while the FSM is in RUN.
REQ-013 div_pend  out  1  high while a divisor write is waiting for the next period boundary.

Function
REQ-014 The FSM SHALL have two states, IDLE and RUN.
REQ-015 IDLE->RUN: en high; counter starts at 0 on the following cycle.
REQ-016 RUN->IDLE: en low, with these effects:
- registered, same edge;
- counter cleared;
- pending write applied;
- no tick in that cycle.
REQ-017 In RUN the counter SHALL increment each cycle and wrap to 0 after reaching div_reg.
REQ-018 tick SHALL be asserted in exactly the cycle the counter equals div_reg.
REQ-019 The first tick after IDLE->RUN SHALL occur div_reg+1 cycles after en is sampled high.
REQ-020 div_reg=0: tick SHALL be high every RUN cycle.
REQ-021 A div_we in IDLE SHALL load div_reg at that edge, and div_pend SHALL stay low.
REQ-022 A div_we in RUN SHALL load a shadow register and set div_pend.
REQ-023 The shadow value SHALL be copied into div_reg at the next wrap edge, clearing div_pend.
REQ-024 A div_we in the same cycle as a tick SHALL be treated as follows:
- the current tick completes with the old value;
- the new value is used for the next period;
- div_pend stays low.
REQ-025 Multiple writes before a boundary: the last write wins.
REQ-026 Arbitration SHALL be round-robin and evaluated only in tick cycles.
REQ-027 The grant SHALL go to the first asserted req at or after index ptr, searching upward with wrap-around.
REQ-028 After a grant, ptr SHALL become gnt_id+1 mod N_REQ.
REQ-029 A tick with req==0 SHALL still pulse, with gnt=0, gnt_id=0 and ptr unchanged.
REQ-030 gnt, gnt_id and tick SHALL be combinational from registered state and req, with zero latency, in the tick cycle.
REQ-031 A req dropped outside a tick cycle SHALL have no effect; no request is latched.

Reset
REQ-032 On rst low, the following SHALL take effect asynchronously:
- state=IDLE, counter=0;
- div_reg and shadow = all ones;
- div_pend=0, ptr=0;
- tick=0, gnt=0, gnt_id=0, busy=0.
REQ-033 Reset asserted mid-period SHALL abandon the period with no tick.
REQ-034 The FSM SHALL leave IDLE no earlier than the first posedge after rst deasserts with en high.

Structure
REQ-035 The shared package div_pkg SHALL hold the state enum {IDLE, RUN} and the default values of CW and N_REQ.
REQ-036 Round-robin selection SHALL be a sub-module rr_pick:
- inputs: req, ptr;
- outputs: one-hot gnt, gnt_id, any;
- purely combinational.
REQ-037 The counter, the divisor registers and the FSM SHALL reside in div_tick_sched.

Verification
REQ-038 The bench SHALL cover the following directed scenarios:
- Reset, then en=1 with div_reg=all ones -> first tick 1024 cycles after en is sampled, period 1024.
- In IDLE write div_val=3, en=1, req=4'b1111 -> ticks every 4 cycles, gnt sequence 0001,0010,0100,1000,0001.
- In RUN (div=3) write div_val=1 two cycles before a tick -> div_pend high until that tick, then period 2.
- req=4'b1010 with ptr=2 -> grant 1000, then 0010; req=0 at a tick -> tick high, gnt=0, ptr unchanged.
- div_val=0, en toggles low mid-run -> tick every cycle while RUN, none the cycle after en falls, busy drops.
- rst pulsed low mid-period (div=7, count=5) -> all outputs 0 immediately, no tick, restart from count 0.
